if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and a direct-mapped instruction cache with one word per line.
- Cache misses are fetched from the memory controller through a req/done handshake.
- Presents {pc, instruction} to IF/ID each cycle. Instruction value 0 marks a bubble.
- Redirects the PC on an EX-resolved branch.

Parameters:
- ICACHE_LINES, 256, number of cache lines (power of two).
- INDEX_W, 8, log2(ICACHE_LINES).
- RESET_PC, 32'h0, PC value loaded at reset.

Ports:
- clk_in  in  1  clock; all state on rising edge
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global ready; 0 freezes all state
- stall_in  in  6  stall vector from stall ctrl; bit 0 freezes this stage
- branch_or_not  in  1  EX redirect strobe
- branch_target  in  32  redirect PC, valid with branch_or_not
- mem_done  in  1  one-cycle pulse: mem_word valid
- mem_word  in  32  fetched instruction, little-endian assembled by mem ctrl
- mem_req  out  1  fetch request, held until mem_done
- mem_addr  out  32  fetch address, stable while mem_req=1
- stall_req  out  1  to stall ctrl: 1 while a miss is outstanding
- output_pc  out  32  PC of presented instruction
- output_instru  out  32  presented instruction; 0 = bubble

Behaviour:
- Reset (rst_in=0, async):
  - pc=RESET_PC; output_pc=0; output_instru=0.
  - mem_req=0; mem_addr=0; stall_req=0.
  - All valid bits cleared; state=IDLE; kill=0.
- rdy_in=0: no register changes, including cache, FSM and kill.
- Cache address split:
  - index = pc[INDEX_W+1:2]
  - tag = pc[31:INDEX_W+2]
  - pc[1:0] is always 0; the branch_target low bits are forced to 0.
- Priority per cycle: branch_or_not > stall_in[0] > normal fetch.
- IDLE, branch_or_not=1:
  - pc<=branch_target.
  - output_pc<=0, output_instru<=0.
  - No memory request.
- IDLE, stall_in[0]=1: pc, outputs and cache all hold.
- IDLE, hit (valid[index] && tag match):
  - Next edge: output_pc<=pc, output_instru<=data, pc<=pc+4 (mod 2^32).
  - Latency 1; sustained throughput 1 instruction/cycle.
- IDLE, miss:
  - output_pc<=0, output_instru<=0.
  - mem_req<=1, mem_addr<=pc, stall_req<=1.
  - Go to FETCH.
- FETCH, no mem_done: mem_req and mem_addr held; outputs 0.
- FETCH, branch_or_not=1: set kill=1, latch branch_target into pc. The outstanding request is not aborted.
- FETCH, mem_done=1:
  - mem_req<=0, stall_req<=0, state<=IDLE.
  - Always write mem_word into the line at mem_addr (valid=1, tag).
  - kill=0 and stall_in[0]=0: output_pc<=mem_addr, output_instru<=mem_word, pc<=mem_addr+4.
  - kill=1: outputs 0; pc keeps the latched target; kill<=0.
  - stall_in[0]=1: outputs hold, pc unchanged; the next unstalled IDLE cycle hits.
- Simultaneous mem_done and branch_or_not in FETCH: treat the fetch as killed. Cache is written, outputs 0, pc<=branch_target.
- mem_req deasserts the edge after mem_done. It must never be high in IDLE.
- The cache is never invalidated except by reset; the design has no self-modifying code.

Decomposition:
- Shared package cpu_defs:
  - fetch FSM state encoding (IDLE, FETCH)
  - NOP/bubble constant 32'h0
  - instruction width 32
  - stall vector width 6 and stall bit indices
- Sub-module icache_dm: direct-mapped tag/valid/data arrays with a combinational lookup (hit, data) and a synchronous write port.
  - Asynchronous active-low clear of the valid bits.
  - Parameters ICACHE_LINES and INDEX_W.

Test Plan:
- Reset then release; mem ctrl returns 32'h00000013 after 5 cycles for addr 0.
  - mem_req=1, mem_addr=0 until done.
  - Then output_pc=0, output_instru=32'h13, pc=4, stall_req=0.
- Loop 0x0..0xC executed twice:
  - First pass: 4 misses.
  - Second pass: outputs 0,4,8,C on 4 consecutive cycles with mem_req=0 throughout.
- Branch to 32'h100 while a miss at 0x8 is outstanding:
  - mem_req holds until done; line 2 is written; outputs stay 0.
  - Next request has mem_addr=32'h100.
- stall_in[0]=1 for 3 cycles on a hit at pc=0x10: outputs and pc unchanged; the fetch resumes after the stall.
- rdy_in=0 while mem_done pulses is invalid stimulus; bench asserts mem ctrl holds done.
  - With rdy_in=0 for 4 cycles mid-FETCH, no state changes.
- Async reset asserted mid-FETCH (no clock edge needed):
  - mem_req=0, outputs 0 immediately.
  - After release, a refetch at 0 misses because valid bits were cleared.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the fetch front end:
// FSM states, bubble value, widths, stall bits.
package cpu_defs;

  localparam int INSTR_W = 32;
  localparam int STALL_W = 6;

  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;
  localparam int STALL_CTL = 5;

  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic {
    S_IDLE,
    S_FETCH
  } fetch_st_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped I-cache, one word per line.
// Ports: clk_in/rst_in (async low clears valid),
// i_rd_idx/i_rd_tag -> o_hit/o_data (comb),
// i_we/i_wr_idx/i_wr_tag/i_wr_data (sync write).
module icache_dm
  import cpu_defs::*;
#(
  parameter int ICACHE_LINES = 256,
  parameter int INDEX_W      = 8,
  parameter int TAG_W        = 32 - INDEX_W - 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [INDEX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0]   i_rd_tag,
  output logic               o_hit,
  output logic [INSTR_W-1:0] o_data,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [INSTR_W-1:0] i_wr_data
);

  logic [ICACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]        r_tag  [ICACHE_LINES];
  logic [INSTR_W-1:0]      r_data [ICACHE_LINES];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit  = r_valid[i_rd_idx] &&
                  (r_tag[i_rd_idx] == i_rd_tag);
  assign o_data = r_data[i_rd_idx];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, I-cache, miss FSM.
// Ports: clk/rst/rdy/stall, EX branch, mem req/done, {pc,instr} out.
module if_stage
  import cpu_defs::*;
#(
  parameter int          ICACHE_LINES = 256,
  parameter int          INDEX_W      = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               branch_or_not,
  input  logic [31:0]        branch_target,
  input  logic               mem_done,
  input  logic [INSTR_W-1:0] mem_word,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  output logic               stall_req,
  output logic [31:0]        output_pc,
  output logic [INSTR_W-1:0] output_instru
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  fetch_st_t          r_state;
  logic [31:0]        r_pc;
  logic               r_kill;
  logic               r_req;
  logic [31:0]        r_addr;
  logic               r_sreq;
  logic [31:0]        r_opc;
  logic [INSTR_W-1:0] r_oins;

  logic               w_hit;
  logic [INSTR_W-1:0] w_data;
  logic               w_we;
  logic               w_stall;
  logic [31:0]        w_tgt;

  assign w_stall = (stall_in & (STALL_W'(1) << STALL_IF)) != '0;
  assign w_tgt   = branch_target & ~32'h3;
  assign w_we    = rdy_in && (r_state == S_FETCH) && mem_done;

  icache_dm #(
    .ICACHE_LINES (ICACHE_LINES),
    .INDEX_W      (INDEX_W),
    .TAG_W        (TAG_W)
  ) u_icache (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_rd_idx  (r_pc[INDEX_W+1:2]),
    .i_rd_tag  (r_pc[31:INDEX_W+2]),
    .o_hit     (w_hit),
    .o_data    (w_data),
    .i_we      (w_we),
    .i_wr_idx  (r_addr[INDEX_W+1:2]),
    .i_wr_tag  (r_addr[31:INDEX_W+2]),
    .i_wr_data (mem_word)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_sreq  <= 1'b0;
      r_opc   <= '0;
      r_oins  <= NOP;
    end else if (rdy_in) begin
      unique case (r_state)
        S_IDLE: begin
          if (branch_or_not) begin
            r_pc   <= w_tgt;
            r_opc  <= '0;
            r_oins <= NOP;
          end else if (w_stall) begin
            r_pc <= r_pc;
          end else if (w_hit) begin
            r_opc  <= r_pc;
            r_oins <= w_data;
            r_pc   <= r_pc + 32'd4;
          end else begin
            r_opc   <= '0;
            r_oins  <= NOP;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
            r_sreq  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem_done) begin
            r_req   <= 1'b0;
            r_sreq  <= 1'b0;
            r_kill  <= 1'b0;
            r_state <= S_IDLE;
            // A same-cycle branch kills the returning word.
            if (branch_or_not) begin
              r_pc   <= w_tgt;
              r_opc  <= '0;
              r_oins <= NOP;
            end else if (r_kill) begin
              r_opc  <= '0;
              r_oins <= NOP;
            end else if (!w_stall) begin
              r_opc  <= r_addr;
              r_oins <= mem_word;
              r_pc   <= r_addr + 32'd4;
            end
          end else begin
            r_opc  <= '0;
            r_oins <= NOP;
            // Request stays in flight; remember to drop it.
            if (branch_or_not) begin
              r_kill <= 1'b1;
              r_pc   <= w_tgt;
            end
          end
        end
      endcase
    end
  end

  assign mem_req       = r_req;
  assign mem_addr      = r_addr;
  assign stall_req     = r_sreq;
  assign output_pc     = r_opc;
  assign output_instru = r_oins;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a hand-driven
// memory controller and hand-computed expectations.
module tb_if_stage;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic [5:0]  stall_in = '0;
  logic        branch_or_not = 1'b0;
  logic [31:0] branch_target = '0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_word = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        stall_req;
  logic [31:0] output_pc;
  logic [31:0] output_instru;

  int n_vec = 0;
  int n_err = 0;

  if_stage dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .stall_in      (stall_in),
    .branch_or_not (branch_or_not),
    .branch_target (branch_target),
    .mem_done      (mem_done),
    .mem_word      (mem_word),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .stall_req     (stall_req),
    .output_pc     (output_pc),
    .output_instru (output_instru)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in)
    if (!rdy_in)
      assert (!mem_done) else $error("mem_done during rdy_in=0");

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a << 8) | 32'h13;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({tag, "_pc"}, output_pc, pc);
    chk({tag, "_ins"}, output_instru, ins);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("req_seen", {31'b0, mem_req}, 32'd1);
  endtask

  // Returns at the negedge after the done edge.
  task automatic serve(input logic [31:0] a, input int dly);
    wait_req();
    chk("req_addr", mem_addr, a);
    repeat (dly) begin
      @(negedge clk_in);
      chk("req_hold", {30'b0, mem_req, stall_req}, 32'd3);
      chk("addr_hold", mem_addr, a);
      chk_out("fetch_bub", 32'h0, 32'h0);
    end
    mem_word = mw(a);
    mem_done = 1'b1;
    @(negedge clk_in);
    mem_done = 1'b0;
    chk("req_drop", {30'b0, mem_req, stall_req}, 32'd0);
  endtask

  task automatic branch(input logic [31:0] t);
    branch_or_not = 1'b1;
    branch_target = t;
    @(negedge clk_in);
    branch_or_not = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_sreq", {31'b0, stall_req}, 32'd0);
    chk_out("rst", 32'h0, 32'h0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    // First miss at 0, five-cycle memory.
    serve(32'h0, 5);
    chk_out("miss0", 32'h0, 32'h13);

    // First pass of the loop: all misses.
    for (int k = 1; k < 4; k++) begin
      serve(32'(4 * k), 2);
      chk_out("miss", 32'(4 * k), mw(32'(4 * k)));
    end

    // Second pass: back-to-back hits.
    branch(32'h0);
    chk_out("br_bub", 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk_out("hit", 32'(4 * k), mw(32'(4 * k)));
      chk("hit_noreq", {31'b0, mem_req}, 32'd0);
    end

    // Fill 0x10 for the stall test.
    serve(32'h10, 1);
    chk_out("miss10", 32'h10, mw(32'h10));

    // Branch during a miss on line 2 (0x408).
    branch(32'h408);
    wait_req();
    chk("kmiss_addr", mem_addr, 32'h408);
    branch(32'h103);
    for (int k = 0; k < 2; k++) begin
      chk("kill_req", {31'b0, mem_req}, 32'd1);
      chk("kill_addr", mem_addr, 32'h408);
      chk_out("kill_bub", 32'h0, 32'h0);
      @(negedge clk_in);
    end
    mem_word = mw(32'h408);
    mem_done = 1'b1;
    @(negedge clk_in);
    mem_done = 1'b0;
    chk("kill_drop", {31'b0, mem_req}, 32'd0);
    chk_out("killed", 32'h0, 32'h0);
    serve(32'h100, 1);
    chk_out("miss100", 32'h100, mw(32'h100));

    // Line 2 was written by the killed fetch.
    branch(32'h408);
    @(negedge clk_in);
    chk_out("hit408", 32'h408, mw(32'h408));
    chk("hit408_noreq", {31'b0, mem_req}, 32'd0);

    // Stall while a hit at 0x10 is pending.
    branch_or_not = 1'b1;
    branch_target = 32'h10;
    @(negedge clk_in);
    branch_or_not = 1'b0;
    stall_in = 6'b000001;
    repeat (3) begin
      @(negedge clk_in);
      chk_out("stall", 32'h0, 32'h0);
      chk("stall_noreq", {31'b0, mem_req}, 32'd0);
    end
    stall_in = '0;
    @(negedge clk_in);
    chk_out("resume", 32'h10, mw(32'h10));

    // rdy_in low mid-FETCH, branch ignored.
    wait_req();
    chk("rdy_addr", mem_addr, 32'h14);
    rdy_in = 1'b0;
    branch_or_not = 1'b1;
    branch_target = 32'h200;
    repeat (4) begin
      @(negedge clk_in);
      chk("rdy_req", {30'b0, mem_req, stall_req}, 32'd3);
      chk("rdy_addr_h", mem_addr, 32'h14);
      chk_out("rdy_bub", 32'h0, 32'h0);
    end
    rdy_in = 1'b1;
    branch_or_not = 1'b0;
    serve(32'h14, 0);
    chk_out("rdy_done", 32'h14, mw(32'h14));

    // Async reset mid-FETCH.
    wait_req();
    chk("pre_rst_addr", mem_addr, 32'h18);
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_req", {30'b0, mem_req, stall_req}, 32'd0);
    chk("arst_addr", mem_addr, 32'h0);
    chk_out("arst", 32'h0, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b1;
    serve(32'h0, 1);
    chk_out("refetch0", 32'h0, 32'h13);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
